// File: rtl/axi_pcie_multififo_accel.sv
// NUM_CH independent host-loopback FIFOs behind one AXI-Lite slave on the PCIe clock.
// Per channel: DATA push/pop, STATUS with W1C sticky errors, CTRL (irq_en/flush), THRESH.
module axi_pcie_multififo_accel #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    pcie_clk,
  input  logic                    pcie_rst,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [NUM_CH-1:0]       irq
);

  localparam int CH_W  = ADDR_WIDTH - 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_THRESH = 2'd3;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic [DATA_WIDTH-1:0] r_mem    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr   [NUM_CH];
  logic [PTR_W-1:0]      r_rptr   [NUM_CH];
  logic [LVL_W-1:0]      r_level  [NUM_CH];
  logic [15:0]           r_thresh [NUM_CH];
  logic [NUM_CH-1:0]     r_ovf, r_unf, r_irq_en, r_irq;

  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_fire, w_ar_fire;
  logic [CH_W-1:0]       w_wch, w_rch;
  logic [1:0]            w_woff, w_roff;
  logic                  w_wch_ok, w_rch_ok, w_strb_full;
  logic [NUM_CH-1:0]     w_wdec, w_rdec, w_full, w_empty;
  logic [NUM_CH-1:0]     w_push, w_pop, w_flush, w_ovf_set, w_unf_set;
  logic [NUM_CH-1:0]     w_ovf_clr, w_unf_clr, w_ctrl_wr, w_thr_wr;
  logic [1:0]            w_bresp, w_rd_resp;
  logic [DATA_WIDTH-1:0] w_rd_data, w_cand;
  logic                  w_unused;

  assign w_wch       = s_axi_awaddr[ADDR_WIDTH-1:4];
  assign w_woff      = s_axi_awaddr[3:2];
  assign w_rch       = s_axi_araddr[ADDR_WIDTH-1:4];
  assign w_roff      = s_axi_araddr[3:2];
  assign w_wch_ok    = (int'(w_wch) < NUM_CH);
  assign w_rch_ok    = (int'(w_rch) < NUM_CH);
  assign w_strb_full = (s_axi_wstrb == {STRB_W{1'b1}});
  assign w_unused    = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Write FSM state register
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state; AW and W are accepted together in one cycle
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_fire    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (s_axi_awvalid && s_axi_wvalid && !pcie_rst) begin
          w_aw_fire    = 1'b1;
          w_wstate_nxt = W_RESP;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_wstate_nxt = W_IDLE;
        else              w_wstate_nxt = W_RESP;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ar_fire    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (s_axi_arvalid && !pcie_rst) begin
          w_ar_fire    = 1'b1;
          w_rstate_nxt = R_RESP;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_RESP: begin
        if (s_axi_rready) w_rstate_nxt = R_IDLE;
        else              w_rstate_nxt = R_RESP;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign s_axi_awready = w_aw_fire;
  assign s_axi_wready  = w_aw_fire;
  assign s_axi_arready = w_ar_fire;
  assign s_axi_bvalid  = (r_wstate == W_RESP);
  assign s_axi_rvalid  = (r_rstate == R_RESP);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign irq           = r_irq;

  // Per-channel decode and event strobes; full/empty use the pre-cycle level
  always_comb begin
    w_wdec = {NUM_CH{1'b0}};
    w_rdec = {NUM_CH{1'b0}};
    w_full = {NUM_CH{1'b0}};
    w_empty = {NUM_CH{1'b0}};
    w_push = {NUM_CH{1'b0}};
    w_pop = {NUM_CH{1'b0}};
    w_flush = {NUM_CH{1'b0}};
    w_ovf_set = {NUM_CH{1'b0}};
    w_unf_set = {NUM_CH{1'b0}};
    w_ovf_clr = {NUM_CH{1'b0}};
    w_unf_clr = {NUM_CH{1'b0}};
    w_ctrl_wr = {NUM_CH{1'b0}};
    w_thr_wr = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      w_wdec[c]    = w_wch_ok && (int'(w_wch) == c);
      w_rdec[c]    = w_rch_ok && (int'(w_rch) == c);
      w_full[c]    = (r_level[c] == LVL_W'(FIFO_DEPTH));
      w_empty[c]   = (r_level[c] == {LVL_W{1'b0}});
      w_push[c]    = w_aw_fire && w_wdec[c] && (w_woff == OFF_DATA) && w_strb_full && !w_full[c];
      w_ovf_set[c] = w_aw_fire && w_wdec[c] && (w_woff == OFF_DATA) && w_strb_full && w_full[c];
      w_ovf_clr[c] = w_aw_fire && w_wdec[c] && (w_woff == OFF_STATUS) && s_axi_wstrb[3] && s_axi_wdata[24];
      w_unf_clr[c] = w_aw_fire && w_wdec[c] && (w_woff == OFF_STATUS) && s_axi_wstrb[3] && s_axi_wdata[25];
      w_ctrl_wr[c] = w_aw_fire && w_wdec[c] && (w_woff == OFF_CTRL) && s_axi_wstrb[0];
      w_flush[c]   = w_ctrl_wr[c] && s_axi_wdata[1];
      w_thr_wr[c]  = w_aw_fire && w_wdec[c] && (w_woff == OFF_THRESH);
      w_pop[c]     = w_ar_fire && w_rdec[c] && (w_roff == OFF_DATA) && !w_empty[c];
      w_unf_set[c] = w_ar_fire && w_rdec[c] && (w_roff == OFF_DATA) && w_empty[c];
    end
  end

  // Write response code for the transfer being accepted
  always_comb begin
    w_bresp = RESP_OKAY;
    if (!w_wch_ok) begin
      w_bresp = RESP_DECERR;
    end else if ((w_woff == OFF_DATA) && (!w_strb_full || |(w_wdec & w_full))) begin
      w_bresp = RESP_SLVERR;
    end else begin
      w_bresp = RESP_OKAY;
    end
  end

  // Read data/response mux; unselected channels contribute zero
  always_comb begin
    w_rd_data = {DATA_WIDTH{1'b0}};
    w_cand    = {DATA_WIDTH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      case (w_roff)
        OFF_DATA:   w_cand = w_empty[c] ? {DATA_WIDTH{1'b0}} : r_mem[c][r_rptr[c]];
        OFF_STATUS: w_cand = DATA_WIDTH'({6'b0, r_unf[c], r_ovf[c], 6'b0, w_full[c], w_empty[c],
                                          16'(r_level[c])});
        OFF_CTRL:   w_cand = DATA_WIDTH'(r_irq_en[c]);
        OFF_THRESH: w_cand = DATA_WIDTH'(r_thresh[c]);
        default:    w_cand = {DATA_WIDTH{1'b0}};
      endcase
      w_rd_data = w_rd_data | (w_rdec[c] ? w_cand : {DATA_WIDTH{1'b0}});
    end
    w_rd_resp = !w_rch_ok ? RESP_DECERR :
                (((w_roff == OFF_DATA) && |(w_rdec & w_empty)) ? RESP_SLVERR : RESP_OKAY);
  end

  // Response registers, loaded at address acceptance and held until handshake
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      r_bresp <= 2'b00;
      r_rresp <= 2'b00;
      r_rdata <= {DATA_WIDTH{1'b0}};
    end else begin
      if (w_aw_fire) r_bresp <= w_bresp;
      if (w_ar_fire) begin
        r_rresp <= w_rd_resp;
        r_rdata <= w_rd_data;
      end
    end
  end

  // FIFO storage; contents are don't-care while the level says empty
  always_ff @(posedge pcie_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) r_mem[c][r_wptr[c]] <= s_axi_wdata;
    end
  end

  // Per-channel pointers, level, sticky errors, control and registered irq
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c]   <= {PTR_W{1'b0}};
        r_rptr[c]   <= {PTR_W{1'b0}};
        r_level[c]  <= {LVL_W{1'b0}};
        r_thresh[c] <= 16'h0000;
      end
      r_ovf    <= {NUM_CH{1'b0}};
      r_unf    <= {NUM_CH{1'b0}};
      r_irq_en <= {NUM_CH{1'b0}};
      r_irq    <= {NUM_CH{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // flush overrides a same-cycle pop; the pop already captured the old head
        if (w_flush[c]) begin
          r_wptr[c]  <= {PTR_W{1'b0}};
          r_rptr[c]  <= {PTR_W{1'b0}};
          r_level[c] <= {LVL_W{1'b0}};
        end else begin
          if (w_push[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
          if (w_pop[c])  r_rptr[c] <= r_rptr[c] + 1'b1;
          if (w_push[c] && !w_pop[c])      r_level[c] <= r_level[c] + 1'b1;
          else if (w_pop[c] && !w_push[c]) r_level[c] <= r_level[c] - 1'b1;
        end
        r_ovf[c] <= w_ovf_set[c] | (r_ovf[c] & ~w_ovf_clr[c]);
        r_unf[c] <= w_unf_set[c] | (r_unf[c] & ~w_unf_clr[c]);
        if (w_ctrl_wr[c]) r_irq_en[c] <= s_axi_wdata[0];
        if (w_thr_wr[c] && s_axi_wstrb[0]) r_thresh[c][7:0]  <= s_axi_wdata[7:0];
        if (w_thr_wr[c] && s_axi_wstrb[1]) r_thresh[c][15:8] <= s_axi_wdata[15:8];
        r_irq[c] <= r_irq_en[c] && (r_thresh[c] != 16'h0000) && (16'(r_level[c]) >= r_thresh[c]);
      end
    end
  end

endmodule

// File: doc/axi_pcie_multififo_accel.md
Name: axi_pcie_multififo_accel

Overview:
- Parametrised successor to the single-FIFO AXI-Lite accelerator.
- Provides NUM_CH independent host-loopback FIFOs behind one AXI-Lite slave on the PCIe clock domain.
- Per channel: host writes to DATA push, host reads of DATA pop, plus status, flush, fill threshold and level-triggered interrupt.
- Instantiated directly by accelerator_mod in place of the single-channel block.

Parameters:
- DATA_WIDTH, 32: AXI data width and FIFO word width.
- ADDR_WIDTH, 8: AXI address width; addr[3:0] = register offset, addr[ADDR_WIDTH-1:4] = channel index.
- NUM_CH, 4: number of channels, 1..(2**(ADDR_WIDTH-4)).
- FIFO_DEPTH, 16: words per channel; power of two, 2..32768.

Ports:
- pcie_clk  in  1  sole clock.
- pcie_rst  in  1  reset: one clock; reset is synchronous and active-high.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid  in  1;  s_axi_awready  out  1.
- s_axi_wdata  in  DATA_WIDTH;  s_axi_wstrb  in  DATA_WIDTH/8;  s_axi_wvalid  in  1;  s_axi_wready  out  1.
- s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1.
- s_axi_araddr  in  ADDR_WIDTH;  s_axi_arvalid  in  1;  s_axi_arready  out  1.
- s_axi_rdata  out  DATA_WIDTH;  s_axi_rresp  out  2;  s_axi_rvalid  out  1;  s_axi_rready  in  1.
- irq  out  NUM_CH  per-channel level interrupt, registered.

Behaviour:

Reset (pcie_rst=1 on a pcie_clk edge):
- All ready/valid outputs 0; bresp, rresp, rdata 0; irq 0.
- All FIFOs empty; sticky bits, irq_en and THRESH cleared to 0.

Register map (byte offset within channel):
- 0x0 DATA: write pushes, read pops.
- 0x4 STATUS: [15:0] level, [16] empty, [17] full, [24] overflow (W1C), [25] underflow (W1C); other bits read 0.
- 0x8 CTRL: [0] irq_en (R/W); [1] flush (write-1, self-clearing, reads 0).
- 0xC THRESH: [15:0] R/W.

Write channel (states W_IDLE, W_RESP):
- In W_IDLE, awready=wready=1 for exactly one cycle when awvalid&&wvalid are both high; the address and data are accepted together. Go to W_RESP with bvalid=1 the next cycle.
- Hold bvalid and bresp stable until bready; return to W_IDLE in the cycle after the bvalid&&bready handshake.
- One outstanding write at a time.

Read channel (states R_IDLE, R_RESP):
- In R_IDLE, arready=1 for one cycle when arvalid is high.
- rvalid, rdata and rresp are registered in the next cycle and held until rready.
- One outstanding read at a time.

DATA push:
- wstrb must be all-ones. Otherwise bresp=SLVERR (2'b10) and no push.
- Push to a full FIFO: data dropped, overflow sticky set, bresp=SLVERR.

DATA pop:
- The head word is captured into rdata at AR acceptance.
- Pop from an empty FIFO: rdata=0, rresp=SLVERR, underflow sticky set.

Other register writes:
- STATUS and THRESH honour wstrb per byte; CTRL uses byte 0.
- Writes to STATUS affect only the W1C bits.

Decode errors:
- Channel index >= NUM_CH returns DECERR (2'b11) with rdata=0, and has no side effect.
- Any address is 4-byte aligned by ignoring addr[1:0].

Simultaneous events:
- A push and a pop to the same channel in the same cycle both take effect and level is unchanged.
- Full/empty checks use the pre-cycle state: a push to a full FIFO is rejected even with a simultaneous pop, and a pop from an empty FIFO is rejected even with a simultaneous push.

Flush:
- Pointers and level go to 0 at the CTRL write edge.
- Sticky bits are not cleared by flush.
- A same-cycle pop on that channel sees the pre-flush head.

Pointer arithmetic:
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- level is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH, zero-extended into [15:0].

Interrupt:
- irq[ch] is registered: 1 the cycle after irq_en && THRESH!=0 && level>=THRESH holds; clears the cycle after the condition drops.

Reset mid-transaction:
- Aborts any pending response; bvalid/rvalid drop the next cycle and all state returns to the reset values.

Test Plan:
1. Write 0xA5A5_0001..0xA5A5_0010 to ch0 DATA (FIFO_DEPTH=16) -> 16 OKAY responses; STATUS=0x0002_0010. 17th write -> SLVERR, STATUS bit24 set. Read 16 DATA words -> same data in order. 17th read -> rdata=0, SLVERR, bit25 set. Write 0x0300_0000 to STATUS -> sticky bits clear.
2. ch2 THRESH=4, CTRL=1, push 3 words -> irq=4'b0000. 4th push -> irq[2]=1 one cycle after the B handshake. Pop 1 word -> irq[2] falls.
3. Push 5 words to ch1, write CTRL=0x3 -> STATUS level 0, empty=1. Next DATA read -> SLVERR. irq_en stays 1.
4. Hold bready=0 for 10 cycles with a new awvalid/wvalid pending -> awready stays 0 and bvalid stays 1. After bready, the second write completes.
5. Read addr 0x40 (channel 4, NUM_CH=4) -> rresp=2'b11, rdata=0, no FIFO changes. DATA write with wstrb=4'b0111 -> SLVERR, level unchanged.
6. Assert pcie_rst while rvalid=1 with ch3 holding 7 words -> rvalid=0 and level=0 the next cycle; a subsequent read of ch3 STATUS returns 0x0001_0000.
